// File: rtl/histogram_serializer_pkg.sv
// rtl/histogram_serializer_pkg.sv - shared state type and index-width helper
package histogram_serializer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Index fields stay at least one bit wide so degenerate sizes of 1 still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/histogram_serializer_nested_index_counter.sv
// rtl/histogram_serializer_nested_index_counter.sv - two-level wrap counter (inner, outer)
module nested_index_counter
  import histogram_serializer_pkg::*;
#(
  parameter int INNER = 6,
  parameter int OUTER = 1,
  localparam int IW = idx_w(INNER),
  localparam int OW = idx_w(OUTER)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_zero_i,
  input  logic          advance_i,
  output logic [IW-1:0] inner_idx_o,
  output logic [OW-1:0] outer_idx_o,
  output logic          at_end_o
);

  localparam logic [IW-1:0] INNER_LAST = IW'(INNER - 1);
  localparam logic [OW-1:0] OUTER_LAST = OW'(OUTER - 1);

  logic [IW-1:0] inner_q, inner_d;
  logic [OW-1:0] outer_q, outer_d;
  logic          inner_wrap;

  assign inner_wrap = (inner_q == INNER_LAST);

  // load_zero wins over advance so a reload on the final step restarts cleanly.
  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (load_zero_i) begin
      inner_d = '0;
      outer_d = '0;
    end else if (advance_i) begin
      if (inner_wrap) begin
        inner_d = '0;
        outer_d = (outer_q == OUTER_LAST) ? '0 : outer_q + 1'b1;
      end else begin
        inner_d = inner_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  assign inner_idx_o = inner_q;
  assign outer_idx_o = outer_q;
  assign at_end_o    = inner_wrap && (outer_q == OUTER_LAST);

endmodule

// File: rtl/histogram_serializer.sv
// rtl/histogram_serializer.sv - captures the bucket array on in_done and streams it word by word
module histogram_serializer
  import histogram_serializer_pkg::*;
#(
  parameter int PRECISION    = 8,
  parameter int NUM_FEATURES = 1,
  parameter int M            = 6,
  parameter int FRAME_CNT_W  = 16,
  localparam int FW = idx_w(NUM_FEATURES),
  localparam int BW = idx_w(M)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          clr,
  input  logic                                          in_done,
  input  logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0] in_data,
  output logic [PRECISION-1:0]                          m_data,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic                                          m_last,
  output logic [FW-1:0]                                 m_feat_idx,
  output logic [BW-1:0]                                 m_bucket_idx,
  output logic                                          busy,
  output logic                                          overflow,
  output logic [FRAME_CNT_W-1:0]                        frame_count
);

  state_e                                        state_q, state_d;
  logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0] buf_q, buf_d;
  logic                                          overflow_q, overflow_d;
  logic [FRAME_CNT_W-1:0]                        frame_count_q, frame_count_d;

  logic [FW-1:0] feat;
  logic [BW-1:0] bucket;
  logic          at_end;
  logic          clear, streaming, xfer, final_xfer, capture;

  assign clear      = rst | clr;
  assign streaming  = (state_q == STREAM);
  assign xfer       = streaming & m_ready;
  assign final_xfer = xfer & at_end;
  // A frame arriving exactly on the last beat is chained without a bubble.
  assign capture    = in_done & (~streaming | final_xfer);

  nested_index_counter #(
    .INNER(M),
    .OUTER(NUM_FEATURES)
  ) u_idx (
    .clk         (clk),
    .rst         (clear),
    .load_zero_i (capture),
    .advance_i   (xfer),
    .inner_idx_o (bucket),
    .outer_idx_o (feat),
    .at_end_o    (at_end)
  );

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    if (capture) buf_d = in_data;
    if (final_xfer) frame_count_d = frame_count_q + 1'b1;
    if (in_done && streaming && !final_xfer) overflow_d = 1'b1;
    case (state_q)
      IDLE:   if (in_done) state_d = STREAM;
      STREAM: if (final_xfer && !in_done) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_valid      = streaming;
  assign busy         = streaming;
  assign m_data       = streaming ? buf_q[feat][bucket] : '0;
  assign m_last       = streaming & at_end;
  assign m_feat_idx   = feat;
  assign m_bucket_idx = bucket;
  assign overflow     = overflow_q;
  assign frame_count  = frame_count_q;

endmodule
